int_mul_var_lat: RTL and testbench

//  Iterative, variable-latency 32x32->32 integer multiplier; the consumer of the

---
 rtl/int_mul_var_lat.sv | 142 ++++++++++++++
 tb/tb_int_mul_var_lat.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/int_mul_var_lat.sv
// Iterative variable-latency multiplier (low p_nbits of a*b). Each CALC cycle
// adds the multiplicand when b[0] is set, then skips the zero run above bit 0.
module int_mul_var_lat #(
  parameter int p_nbits     = 32,
  parameter int p_max_shamt = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 istream_val,
  output logic                 istream_rdy,
  input  logic [2*p_nbits-1:0] istream_msg,
  output logic                 ostream_val,
  input  logic                 ostream_rdy,
  output logic [p_nbits-1:0]   ostream_msg
);

  localparam int SW = $clog2(p_nbits) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [p_nbits-1:0] r_a;
  logic [p_nbits-1:0] r_b;
  logic [p_nbits-1:0] r_result;
  logic [p_nbits-1:0] w_a_next;
  logic [p_nbits-1:0] w_b_next;
  logic [p_nbits-1:0] w_result_next;
  logic [p_nbits-1:0] w_b_shr1;
  logic [p_nbits-1:0] w_b_shifted;
  logic [p_nbits-1:0] w_a_shifted;
  logic [SW-1:0]      w_tz;
  logic [SW-1:0]      w_shamt_raw;
  logic [SW-1:0]      w_shamt;
  logic               r_istream_rdy;
  logic               r_ostream_val;
  logic               w_in_fire;
  logic               w_out_fire;

  // Trailing-zero count; an all-zero word reports p_nbits-1.
  function automatic logic [SW-1:0] f_tz(input logic [p_nbits-1:0] v);
    logic [SW-1:0] cnt;
    cnt = SW'(p_nbits - 1);
    for (int i = p_nbits - 1; i >= 0; i--) begin
      if (v[i]) begin
        cnt = SW'(i);
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

  assign w_in_fire  = istream_val & r_istream_rdy;
  assign w_out_fire = r_ostream_val & ostream_rdy;

  // Zero-run skip: shift past b[0] and every zero above it, capped by the shifter width.
  always_comb begin
    w_b_shr1    = r_b >> 1;
    w_tz        = f_tz(w_b_shr1);
    w_shamt_raw = w_tz + SW'(1);
    if (w_shamt_raw > SW'(p_max_shamt)) begin
      w_shamt = SW'(p_max_shamt);
    end else begin
      w_shamt = w_shamt_raw;
    end
    w_b_shifted = r_b >> w_shamt;
    w_a_shifted = r_a << w_shamt;
  end

  // Next-state and datapath next values.
  always_comb begin
    w_state_next  = r_state;
    w_a_next      = r_a;
    w_b_next      = r_b;
    w_result_next = r_result;
    case (r_state)
      S_IDLE: begin
        if (w_in_fire) begin
          w_a_next      = istream_msg[2*p_nbits-1:p_nbits];
          w_b_next      = istream_msg[p_nbits-1:0];
          w_result_next = {p_nbits{1'b0}};
          w_state_next  = S_CALC;
        end else begin
          w_state_next  = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_b[0]) begin
          w_result_next = r_result + r_a;
        end else begin
          w_result_next = r_result;
        end
        w_a_next = w_a_shifted;
        w_b_next = w_b_shifted;
        if (w_b_shifted == {p_nbits{1'b0}}) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_CALC;
        end
      end
      S_DONE: begin
        if (w_out_fire) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, operand and handshake registers; handshake flags decode the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_a           <= {p_nbits{1'b0}};
      r_b           <= {p_nbits{1'b0}};
      r_result      <= {p_nbits{1'b0}};
      r_istream_rdy <= 1'b0;
      r_ostream_val <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_a           <= w_a_next;
      r_b           <= w_b_next;
      r_result      <= w_result_next;
      r_istream_rdy <= (w_state_next == S_IDLE);
      r_ostream_val <= (w_state_next == S_DONE);
    end
  end

  assign istream_rdy = r_istream_rdy;
  assign ostream_val = r_ostream_val;
  assign ostream_msg = r_result;

endmodule

// File: tb/tb_int_mul_var_lat.sv
// Directed bench for int_mul_var_lat: default-width instance plus a p_max_shamt=4 instance.
module tb_int_mul_var_lat;

  logic        clk;
  logic        reset;
  logic [63:0] istream_msg;
  logic        iv1, ir1, ov1, or1;
  logic [31:0] om1;
  logic        iv2, ir2, ov2, or2;
  logic [31:0] om2;
  int          checks;
  int          failures;

  int_mul_var_lat #(.p_nbits(32), .p_max_shamt(32)) dut (
    .clk(clk), .reset(reset),
    .istream_val(iv1), .istream_rdy(ir1), .istream_msg(istream_msg),
    .ostream_val(ov1), .ostream_rdy(or1), .ostream_msg(om1)
  );

  int_mul_var_lat #(.p_nbits(32), .p_max_shamt(4)) dut_cap (
    .clk(clk), .reset(reset),
    .istream_val(iv2), .istream_rdy(ir2), .istream_msg(istream_msg),
    .ostream_val(ov2), .ostream_rdy(or2), .ostream_msg(om2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_of(input bit sel);
    return sel ? ir2 : ir1;
  endfunction

  function automatic logic val_of(input bit sel);
    return sel ? ov2 : ov1;
  endfunction

  function automatic logic [31:0] msg_of(input bit sel);
    return sel ? om2 : om1;
  endfunction

  // Runs one transaction; exp_lat counts cycles from the fire cycle to the first ostream_val cycle.
  task automatic run_op(input bit sel, input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int exp_lat, input int hold);
    int n;
    n = 0;
    while (!rdy_of(sel) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_rdy"}, {31'd0, rdy_of(sel)}, 32'd1);
    istream_msg = {a, b};
    if (sel) iv2 = 1'b1; else iv1 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      iv1 = 1'b0;
      iv2 = 1'b0;
      n++;
      if (!val_of(sel) && n > 1) chk({tag, "_rdy_busy"}, {31'd0, rdy_of(sel)}, 32'd0);
    end while (!val_of(sel) && n < 200);
    chk({tag, "_val"}, {31'd0, val_of(sel)}, 32'd1);
    chk({tag, "_msg"}, msg_of(sel), exp);
    if (exp_lat > 0) chk({tag, "_lat"}, n, exp_lat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_val"}, {31'd0, val_of(sel)}, 32'd1);
      chk({tag, "_hold_msg"}, msg_of(sel), exp);
      chk({tag, "_hold_inrdy"}, {31'd0, rdy_of(sel)}, 32'd0);
    end
    if (sel) or2 = 1'b1; else or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
    or2 = 1'b0;
    chk({tag, "_post_val"}, {31'd0, val_of(sel)}, 32'd0);
    chk({tag, "_post_inrdy"}, {31'd0, rdy_of(sel)}, 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    iv1         = 1'b0;
    iv2         = 1'b0;
    or1         = 1'b0;
    or2         = 1'b0;
    istream_msg = 64'd0;
    repeat (3) @(negedge clk);
    chk("reset_inrdy", {31'd0, ir1}, 32'd0);
    chk("reset_outval", {31'd0, ov1}, 32'd0);
    chk("reset_msg", om1, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_inrdy", {31'd0, ir1}, 32'd1);
    chk("idle_outval", {31'd0, ov1}, 32'd0);

    // Latency = popcount(b) + (b[0] ? 0 : 1) CALC cycles, plus one.
    run_op(1'b0, "a3b5", 32'd3, 32'd5, 32'd15, 3, 0);
    run_op(1'b0, "b0", 32'h0000_1234, 32'd0, 32'd0, 2, 0);
    run_op(1'b0, "a0bff", 32'd0, 32'hFFFF_FFFF, 32'd0, 33, 0);
    run_op(1'b0, "wrap", 32'd7, 32'h8000_0000, 32'h8000_0000, 3, 0);
    run_op(1'b0, "neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd3, 32, 5);
    run_op(1'b0, "a10b12", 32'd10, 32'd12, 32'd120, 4, 0);

    // Reset while CALC of a=5,b=0xFF is in progress.
    istream_msg = {32'd5, 32'h0000_00FF};
    iv1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", {31'd0, ir1}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_outval", {31'd0, ov1}, 32'd0);
    chk("midrst_inrdy", {31'd0, ir1}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("afterrst_inrdy", {31'd0, ir1}, 32'd1);
    chk("afterrst_outval", {31'd0, ov1}, 32'd0);
    run_op(1'b0, "a6b7", 32'd6, 32'd7, 32'd42, 4, 0);

    // Bench-modelled operands for wider bit patterns.
    for (int k = 0; k < 20; k++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(1'b0, "rand", ra, rb, ra * rb,
             $countones(rb) + (rb[0] ? 1 : 2), $urandom_range(0, 2));
    end

    // Capped shifter: extra cycles, same product.
    run_op(1'b1, "cap_wrap", 32'd7, 32'h8000_0000, 32'h8000_0000, 10, 0);
    run_op(1'b1, "cap_b0", 32'h0000_1234, 32'd0, 32'd0, 2, 0);
    run_op(1'b1, "cap_a3b5", 32'd3, 32'd5, 32'd15, 3, 0);
    for (int k = 0; k < 10; k++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(1'b1, "cap_rand", ra, rb, ra * rb, 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
